// File: rtl/scheduler_sched_info_loader_pkg.sv
// sched_info_pkg: sched-info entry layout, config-stream field positions and loader states.
package sched_info_pkg;
    localparam int TYPE_W        = 34;
    localparam int ID_W          = 8;
    localparam int CNT_W         = 8;
    localparam int ENTRY_W       = TYPE_W + ID_W + CNT_W;
    localparam int CNT_LSB       = 0;
    localparam int ID_LSB        = CNT_LSB + CNT_W;
    localparam int TYPE_LSB      = ID_LSB + ID_W;
    localparam int HDR_N_LSB     = 0;
    localparam int HDR_N_W       = 8;
    localparam int DESC_TYPE_LSB = 0;
    localparam int DESC_CNT_LSB  = 40;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ENTRY,
        S_DRAIN,
        S_CLEAR
    } loaderState_t;

    function automatic logic [ENTRY_W-1:0] makeEntry(
        input logic [TYPE_W-1:0] taskType,
        input logic [ID_W-1:0]   firstId,
        input logic [CNT_W-1:0]  count
    );
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[TYPE_LSB +: TYPE_W] = taskType;
        e[ID_LSB +: ID_W]     = firstId;
        e[CNT_LSB +: CNT_W]   = count;
        return e;
    endfunction
endpackage

// File: rtl/scheduler_sched_info_loader.sv
// scheduler_sched_info_loader: fills the sched-info memory from a header + descriptor stream,
// assigning first accelerator IDs as a running sum and zero-filling unused entries.
module scheduler_sched_info_loader
    import sched_info_pkg::*;
#(
    parameter int MAX_ACC_TYPES = 16,
    parameter int ACC_TYPE_BITS = $clog2(MAX_ACC_TYPES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [63:0]              cfg_tdata,
    input  logic                     cfg_tvalid,
    output logic                     cfg_tready,
    output logic [ACC_TYPE_BITS-1:0] scheduleData_portA_addr,
    output logic                     scheduleData_portA_en,
    output logic [ENTRY_W-1:0]       scheduleData_portA_din,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [ACC_TYPE_BITS:0]   num_acc_types,
    output logic [7:0]               num_accs
);
    localparam logic [ACC_TYPE_BITS:0] MAX_IDX = (ACC_TYPE_BITS+1)'(MAX_ACC_TYPES);
    localparam logic [HDR_N_W-1:0]     MAX_N   = HDR_N_W'(MAX_ACC_TYPES);

    loaderState_t           state;
    logic [ACC_TYPE_BITS:0] idx;
    logic [ACC_TYPE_BITS:0] loadCnt;
    logic [HDR_N_W-1:0]     drainCnt;
    logic [8:0]             sum;

    logic [HDR_N_W-1:0] hdrN;
    logic [TYPE_W-1:0]  descType;
    logic [CNT_W-1:0]   descCnt;
    logic [8:0]         nextSum;
    logic               hdrOver;
    logic               sumOvf;
    logic               lastEntry;
    logic               accept;
    logic               unusedBits;

    assign cfg_tready = state inside {S_HDR, S_ENTRY, S_DRAIN};

    always_comb begin
        hdrN       = cfg_tdata[HDR_N_LSB +: HDR_N_W];
        descType   = cfg_tdata[DESC_TYPE_LSB +: TYPE_W];
        descCnt    = cfg_tdata[DESC_CNT_LSB +: CNT_W];
        nextSum    = sum + 9'(descCnt);
        hdrOver    = hdrN > MAX_N;
        sumOvf     = nextSum[8];
        lastEntry  = (idx + 1'b1) == loadCnt;
        accept     = cfg_tvalid & cfg_tready;
        unusedBits = ^{cfg_tdata[63:48], cfg_tdata[39:34]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                   <= S_IDLE;
            idx                     <= '0;
            loadCnt                 <= '0;
            drainCnt                <= '0;
            sum                     <= '0;
            scheduleData_portA_addr <= '0;
            scheduleData_portA_en   <= 1'b0;
            scheduleData_portA_din  <= '0;
            busy                    <= 1'b0;
            done                    <= 1'b0;
            error                   <= 1'b0;
            num_acc_types           <= '0;
            num_accs                <= '0;
        end else begin
            scheduleData_portA_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_HDR;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        error <= 1'b0;
                        sum   <= '0;
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        idx      <= '0;
                        loadCnt  <= hdrOver ? MAX_IDX : (ACC_TYPE_BITS+1)'(hdrN);
                        drainCnt <= hdrOver ? hdrN - MAX_N : '0;
                        if (hdrOver) error <= 1'b1;
                        state    <= (hdrN == '0) ? S_CLEAR : S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (accept) begin
                        scheduleData_portA_en   <= 1'b1;
                        scheduleData_portA_addr <= idx[ACC_TYPE_BITS-1:0];
                        // an overflowing entry keeps its ID but gets no instances
                        scheduleData_portA_din  <= makeEntry(descType, sum[7:0], sumOvf ? '0 : descCnt);
                        if (sumOvf || descCnt == '0) error <= 1'b1;
                        if (!sumOvf) sum <= nextSum;
                        idx <= idx + 1'b1;
                        if (lastEntry) state <= (drainCnt != '0) ? S_DRAIN : S_CLEAR;
                    end
                end
                S_DRAIN: begin
                    if (accept) begin
                        drainCnt <= drainCnt - 1'b1;
                        if (drainCnt == 8'd1) state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (idx == MAX_IDX) begin
                        state         <= S_IDLE;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        num_acc_types <= loadCnt;
                        num_accs      <= sum[7:0];
                    end else begin
                        scheduleData_portA_en   <= 1'b1;
                        scheduleData_portA_addr <= idx[ACC_TYPE_BITS-1:0];
                        scheduleData_portA_din  <= '0;
                        idx                     <= idx + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scheduler_sched_info_loader.sv
// tb_scheduler_sched_info_loader: directed loads (normal, empty, oversize, overflow,
// flow control, mid-load reset) checked against a shadow copy of the written memory.
module tb_scheduler_sched_info_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] cfg_tdata = '0;
    logic        cfg_tvalid = 1'b0;
    logic        cfg_tready;
    logic [3:0]  addr;
    logic        en;
    logic [49:0] din;
    logic        busy, done, error;
    logic [4:0]  num_acc_types;
    logic [7:0]  num_accs;

    int nAsserts = 0;
    int nFails = 0;
    logic [49:0] mem [16];
    int wrCnt [16];
    int wrTotal = 0;
    int base [16];
    int baseTotal = 0;

    scheduler_sched_info_loader #(.MAX_ACC_TYPES(16)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cfg_tdata(cfg_tdata),
        .cfg_tvalid(cfg_tvalid),
        .cfg_tready(cfg_tready),
        .scheduleData_portA_addr(addr),
        .scheduleData_portA_en(en),
        .scheduleData_portA_din(din),
        .busy(busy),
        .done(done),
        .error(error),
        .num_acc_types(num_acc_types),
        .num_accs(num_accs)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (en === 1'b1) begin
            mem[addr] = din;
            wrCnt[addr] = wrCnt[addr] + 1;
            wrTotal = wrTotal + 1;
        end
    end

    function automatic logic [63:0] ent(input logic [33:0] t, input logic [7:0] id, input logic [7:0] c);
        return {14'd0, t, id, c};
    endfunction

    function automatic logic [63:0] desc(input logic [33:0] t, input logic [7:0] c);
        return {16'hABCD, c, 6'h3F, t};
    endfunction

    function automatic logic [63:0] hdr(input logic [7:0] n);
        return {56'h12_3456_789A_BCDE, n};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        sync();
        start = 1'b0;
    endtask

    task automatic send(input logic [63:0] d, input int gaps);
        bit ok = 1'b0;
        repeat (gaps) sync();
        cfg_tdata = d;
        cfg_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cfg_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("tready_wait", 64'(cfg_tready), 64'd1);
        sync();
        cfg_tvalid = 1'b0;
    endtask

    task automatic waitDone();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done", 64'(done), 64'd1);
    endtask

    task automatic snap();
        for (int i = 0; i < 16; i++) base[i] = wrCnt[i];
        baseTotal = wrTotal;
    endtask

    task automatic checkReset();
        chk("rst_en", 64'(en), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_din", 64'(din), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_tready", 64'(cfg_tready), 64'd0);
        chk("rst_num_acc_types", 64'(num_acc_types), 64'd0);
        chk("rst_num_accs", 64'(num_accs), 64'd0);
    endtask

    task automatic checkNormal();
        chk("norm_entry0", 64'(mem[0]), ent(34'h100000001, 8'd0, 8'd3));
        chk("norm_entry1", 64'(mem[1]), ent(34'h2, 8'd3, 8'd4));
        for (int i = 2; i < 16; i++) chk("norm_zero_fill", 64'(mem[i]), 64'd0);
        for (int i = 0; i < 16; i++) chk("norm_write_once", 64'(wrCnt[i] - base[i]), 64'd1);
        chk("norm_write_total", 64'(wrTotal - baseTotal), 64'd16);
        chk("norm_busy", 64'(busy), 64'd0);
        chk("norm_error", 64'(error), 64'd0);
        chk("norm_num_acc_types", 64'(num_acc_types), 64'd2);
        chk("norm_num_accs", 64'(num_accs), 64'd7);
        chk("norm_tready", 64'(cfg_tready), 64'd0);
    endtask

    task automatic normalLoad(input int maxGap);
        snap();
        pulseStart();
        send(hdr(8'd2), $urandom_range(maxGap, 0));
        send(desc(34'h100000001, 8'd3), $urandom_range(maxGap, 0));
        send(desc(34'h2, 8'd4), $urandom_range(maxGap, 0));
        waitDone();
        checkNormal();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkReset();

        // normal two-entry load
        sync();
        normalLoad(0);

        // empty load: every entry zero-filled
        sync();
        snap();
        pulseStart();
        @(negedge clk);
        chk("empty_busy", 64'(busy), 64'd1);
        chk("empty_done_cleared", 64'(done), 64'd0);
        sync();
        send(hdr(8'd0), 0);
        waitDone();
        for (int i = 0; i < 16; i++) chk("empty_zero", 64'(mem[i]), 64'd0);
        for (int i = 0; i < 16; i++) chk("empty_write_once", 64'(wrCnt[i] - base[i]), 64'd1);
        chk("empty_num_acc_types", 64'(num_acc_types), 64'd0);
        chk("empty_num_accs", 64'(num_accs), 64'd0);
        chk("empty_error", 64'(error), 64'd0);

        // oversize load: 16 stored, 2 drained, no clear writes
        sync();
        snap();
        pulseStart();
        send(hdr(8'd18), 0);
        for (int i = 0; i < 18; i++) send(desc(34'(i + 1), 8'd1), 0);
        waitDone();
        chk("over_write_total", 64'(wrTotal - baseTotal), 64'd16);
        chk("over_entry0", 64'(mem[0]), ent(34'd1, 8'd0, 8'd1));
        chk("over_entry15", 64'(mem[15]), ent(34'd16, 8'd15, 8'd1));
        chk("over_error", 64'(error), 64'd1);
        chk("over_num_acc_types", 64'(num_acc_types), 64'd16);
        chk("over_num_accs", 64'(num_accs), 64'd16);

        // running-sum overflow
        sync();
        snap();
        pulseStart();
        send(hdr(8'd2), 0);
        send(desc(34'h5, 8'd200), 0);
        send(desc(34'h6, 8'd100), 0);
        waitDone();
        chk("ovf_entry0", 64'(mem[0]), ent(34'h5, 8'd0, 8'd200));
        chk("ovf_entry1", 64'(mem[1]), ent(34'h6, 8'd200, 8'd0));
        chk("ovf_error", 64'(error), 64'd1);
        chk("ovf_num_accs", 64'(num_accs), 64'd200);
        chk("ovf_num_acc_types", 64'(num_acc_types), 64'd2);
        chk("ovf_write_total", 64'(wrTotal - baseTotal), 64'd16);

        // flow control: tvalid gaps plus start pulses while busy
        sync();
        snap();
        pulseStart();
        send(hdr(8'd2), $urandom_range(3, 1));
        pulseStart();
        send(desc(34'h100000001, 8'd3), $urandom_range(3, 1));
        pulseStart();
        send(desc(34'h2, 8'd4), $urandom_range(3, 1));
        waitDone();
        checkNormal();
        repeat (3) @(negedge clk);
        chk("flow_idle_busy", 64'(busy), 64'd0);
        chk("flow_idle_done", 64'(done), 64'd1);

        // reset in the middle of ENTRY, then a clean reload
        sync();
        pulseStart();
        send(hdr(8'd3), 0);
        send(desc(34'h7, 8'd5), 0);
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        checkReset();
        sync();
        normalLoad(0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
